// File: rtl/iob_plic_mt.sv
// iob_plic_mt: multi-target platform-level interrupt controller with an
// IOb native slave port.
//
// Ports:
//   clk, rst       single rising-edge clock, synchronous active-low reset
//   valid, address, wdata, wstrb
//                  IOb request; any wstrb bit set = write, all zero = read
//   rdata, ready   registered response, ready high for one cycle per request
//   src            interrupt inputs (bit i is source ID i+1), synchronous to clk
//   irq            one registered interrupt request per target
//
// Register map (byte offsets):
//   0x0000+4*ID     source priority
//   0x0400          pending vector (read-only, bit ID)
//   0x0480          mode vector (1 = edge, 0 = level)
//   0x0800+0x80*t   enable mask of target t
//   0x1000+0x100*t  threshold of target t
//   0x1004+0x100*t  claim (read) / complete (write) of target t
module iob_plic_mt #(
  parameter int ADDR_W            = 16,
  parameter int DATA_W            = 32,
  parameter int SOURCES           = 8,
  parameter int TARGETS           = 2,
  parameter int PRIORITIES        = 8,
  parameter int MAX_PENDING_COUNT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [SOURCES-1:0]  src,
  output logic [TARGETS-1:0]  irq
);

  localparam int PRIO_W = $clog2(PRIORITIES);
  localparam int CNT_W  = $clog2(MAX_PENDING_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING_COUNT);

  // Per-source state, indexed by source ID (1..SOURCES).
  logic [PRIO_W-1:0]  prio    [1:SOURCES];
  logic [CNT_W-1:0]   cnt     [1:SOURCES];
  logic [CNT_W-1:0]   cnt_nxt [1:SOURCES];
  logic [SOURCES:1]   mode, ins, pend;
  logic [SOURCES:1]   mode_nxt, ins_nxt, pend_nxt;
  logic [SOURCES-1:0] src_q;

  // Per-target state.
  logic [SOURCES:1]   en   [TARGETS];
  logic [PRIO_W-1:0]  thr  [TARGETS];
  logic [4:0]         cand [TARGETS];

  // Address decode.
  logic       wr_req, rd_req;
  logic [4:0] a_id;
  logic [2:0] a_te, a_tc;
  logic       sel_prio, sel_pend, sel_mode, sel_en, sel_thr, sel_clm;

  always_comb begin
    wr_req   = valid & (|wstrb);
    rd_req   = valid & ~(|wstrb);
    a_id     = address[6:2];
    a_te     = address[9:7];
    a_tc     = address[10:8];
    sel_prio = (address[ADDR_W-1:7] == '0) && (address[1:0] == 2'b00) &&
               (a_id != 5'd0) && (int'(a_id) <= SOURCES);
    sel_pend = (address == ADDR_W'('h400));
    sel_mode = (address == ADDR_W'('h480));
    sel_en   = (address[ADDR_W-1:10] == (ADDR_W-10)'(2)) && (address[6:0] == 7'd0) &&
               (int'(a_te) < TARGETS);
    sel_thr  = (address[ADDR_W-1:11] == (ADDR_W-11)'(2)) && (address[7:0] == 8'h00) &&
               (int'(a_tc) < TARGETS);
    sel_clm  = (address[ADDR_W-1:11] == (ADDR_W-11)'(2)) && (address[7:0] == 8'h04) &&
               (int'(a_tc) < TARGETS);
  end

  // Claim / complete for the addressed target.
  logic             clm_fire, cmp_fire;
  logic [4:0]       clm_id, cmp_id;
  logic [SOURCES:1] cmp_en;

  always_comb begin
    clm_id = '0;
    cmp_en = '0;
    for (int unsigned t = 0; t < TARGETS; t++) begin
      if (a_tc == 3'(t)) begin
        clm_id = cand[t];
        cmp_en = en[t];
      end
    end
    clm_fire = rd_req & sel_clm;
    cmp_fire = wr_req & sel_clm & (wdata[DATA_W-1:5] == '0);
    cmp_id   = wdata[4:0];
  end

  // Gateways: next in-service, counter and pending state. Pending is
  // registered from the next-state values so a claim or complete is reflected
  // in arbitration on the cycle right after it is accepted.
  always_comb begin
    logic inc, dec;
    mode_nxt = mode;
    if (wr_req && sel_mode) mode_nxt = wdata[SOURCES:1];
    ins_nxt  = ins;
    pend_nxt = '0;
    for (int unsigned i = 1; i <= SOURCES; i++) begin
      inc        = src[i-1] & ~src_q[i-1];
      dec        = clm_fire && (clm_id == 5'(i)) && (cnt[i] != '0);
      cnt_nxt[i] = cnt[i];
      if (clm_fire && (clm_id == 5'(i)))
        ins_nxt[i] = 1'b1;
      if (cmp_fire && (cmp_id == 5'(i)) && ins[i] && cmp_en[i])
        ins_nxt[i] = 1'b0;
      // A mode change restarts the edge count; level sources never count.
      if ((mode_nxt[i] != mode[i]) || !mode[i])
        cnt_nxt[i] = '0;
      else if (inc && !dec)
        cnt_nxt[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + 1'b1;
      else if (dec && !inc)
        cnt_nxt[i] = cnt[i] - 1'b1;
      pend_nxt[i] = mode_nxt[i] ? ((cnt_nxt[i] != '0) && !ins_nxt[i])
                                : (src[i-1] && !ins_nxt[i]);
    end
  end

  // Arbitration: strict '>' while scanning upward keeps the lowest ID on ties
  // and starting from the threshold enforces priority > threshold.
  always_comb begin
    logic [PRIO_W-1:0] best;
    for (int unsigned t = 0; t < TARGETS; t++) begin
      best    = thr[t];
      cand[t] = '0;
      for (int unsigned i = 1; i <= SOURCES; i++) begin
        if (pend[i] && en[t][i] && (prio[i] > best)) begin
          best    = prio[i];
          cand[t] = 5'(i);
        end
      end
    end
  end

  // Read mux.
  logic [DATA_W-1:0] rd_val;

  always_comb begin
    rd_val = '0;
    if (sel_prio) begin
      for (int unsigned i = 1; i <= SOURCES; i++)
        if (a_id == 5'(i)) rd_val = DATA_W'(prio[i]);
    end else if (sel_pend) begin
      rd_val[SOURCES:1] = pend;
    end else if (sel_mode) begin
      rd_val[SOURCES:1] = mode;
    end else if (sel_en) begin
      for (int unsigned t = 0; t < TARGETS; t++)
        if (a_te == 3'(t)) rd_val[SOURCES:1] = en[t];
    end else if (sel_thr) begin
      for (int unsigned t = 0; t < TARGETS; t++)
        if (a_tc == 3'(t)) rd_val = DATA_W'(thr[t]);
    end else if (sel_clm) begin
      rd_val = DATA_W'(clm_id);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ready <= 1'b0;
      rdata <= '0;
      irq   <= '0;
      mode  <= '0;
      ins   <= '0;
      pend  <= '0;
      src_q <= '0;
      for (int unsigned i = 1; i <= SOURCES; i++) begin
        prio[i] <= '0;
        cnt[i]  <= '0;
      end
      for (int unsigned t = 0; t < TARGETS; t++) begin
        en[t]  <= '0;
        thr[t] <= '0;
      end
    end else begin
      ready <= valid;
      rdata <= rd_req ? rd_val : '0;
      src_q <= src;
      mode  <= mode_nxt;
      ins   <= ins_nxt;
      pend  <= pend_nxt;
      for (int unsigned i = 1; i <= SOURCES; i++) begin
        cnt[i] <= cnt_nxt[i];
        if (wr_req && sel_prio && (a_id == 5'(i)))
          prio[i] <= wdata[PRIO_W-1:0];
      end
      for (int unsigned t = 0; t < TARGETS; t++) begin
        if (wr_req && sel_en && (a_te == 3'(t)))
          en[t] <= wdata[SOURCES:1];
        if (wr_req && sel_thr && (a_tc == 3'(t)))
          thr[t] <= wdata[PRIO_W-1:0];
        irq[t] <= (cand[t] != '0);
      end
    end
  end

endmodule

// File: tb/tb_iob_plic_mt.sv
// tb_iob_plic_mt: self-checking bench for iob_plic_mt with default parameters.
// Bus reads push their expected data into a scoreboard queue when issued; a
// monitor pops and compares on each ready. irq is checked inline per test.
module tb_iob_plic_mt;

  localparam logic [15:0] PEND = 16'h0400;
  localparam logic [15:0] MODE = 16'h0480;
  localparam logic [15:0] EN0  = 16'h0800;
  localparam logic [15:0] EN1  = 16'h0880;
  localparam logic [15:0] THR0 = 16'h1000;
  localparam logic [15:0] THR1 = 16'h1100;
  localparam logic [15:0] CLM0 = 16'h1004;
  localparam logic [15:0] CLM1 = 16'h1104;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] address = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [7:0]  src = '0;
  logic [1:0]  irq;

  int checks = 0;
  int errors = 0;

  bit          sb_rd   [$];
  logic [31:0] sb_exp  [$];
  string       sb_name [$];

  always #5 clk = ~clk;

  iob_plic_mt #(
    .ADDR_W(16), .DATA_W(32), .SOURCES(8), .TARGETS(2),
    .PRIORITIES(8), .MAX_PENDING_COUNT(8)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
    .wstrb(wstrb), .rdata(rdata), .ready(ready), .src(src), .irq(irq)
  );

  // Bus monitor / scoreboard.
  logic        exp_ready = 1'b0;
  bit          m_rd;
  logic [31:0] m_exp;
  string       m_name;

  always @(posedge clk) exp_ready <= valid & rst;

  always @(negedge clk) begin
    checks++;
    if (ready !== exp_ready) begin
      errors++;
      $display("FAIL ready_timing: got %b expected %b at %0t", ready, exp_ready, $time);
    end
    if (ready === 1'b1) begin
      if (sb_rd.size() == 0) begin
        errors++;
        $display("FAIL spurious_ready: ready with no request at %0t", $time);
      end else begin
        m_rd   = sb_rd.pop_front();
        m_exp  = sb_exp.pop_front();
        m_name = sb_name.pop_front();
        if (m_rd) begin
          checks++;
          if (rdata !== m_exp) begin
            errors++;
            $display("FAIL %s: rdata got 0x%08h expected 0x%08h", m_name, rdata, m_exp);
          end
        end
      end
    end
  end

  function automatic logic [15:0] a_prio(input int id);
    return 16'(4 * id);
  endfunction

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input bit we, input logic [15:0] a, input logic [31:0] d,
                       input logic [31:0] e, input string nm);
    valid   = 1'b1;
    address = a;
    wdata   = d;
    wstrb   = we ? 4'hF : 4'h0;
    sb_rd.push_back(!we);
    sb_exp.push_back(e);
    sb_name.push_back(nm);
    @(posedge clk);
    #1;
    valid = 1'b0;
    wstrb = 4'h0;
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
    issue(1'b1, a, d, 32'h0, "write");
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [31:0] e, input string nm);
    issue(1'b0, a, 32'h0, e, nm);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    cycles(3);
    checks++;
    if (irq !== 2'b00) begin
      errors++;
      $display("FAIL reset_irq: got %b expected 00", irq);
    end
    rst = 1'b1;
    cycles(1);
    bus_rd(a_prio(1), 32'h0, "reset_prio1");
    bus_rd(EN0, 32'h0, "reset_en0");
    bus_rd(CLM0, 32'h0, "reset_claim0");
    bus_rd(PEND, 32'h0, "reset_pend");
  endtask

  task automatic test_level;
    bus_wr(a_prio(3), 32'd5);
    bus_wr(EN0, 32'h08);
    bus_wr(THR0, 32'd0);
    src[2] = 1'b1;
    cycles(1);
    checks++;
    if (irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL level_latency1: irq0 got %b expected 0", irq[0]);
    end
    cycles(1);
    checks++;
    if (irq[0] !== 1'b1) begin
      errors++;
      $display("FAIL level_latency2: irq0 got %b expected 1", irq[0]);
    end
    bus_rd(PEND, 32'h08, "level_pend");
    bus_rd(CLM0, 32'd3, "level_claim");
    cycles(1);
    checks++;
    if (irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL level_irq_drop: irq0 got %b expected 0", irq[0]);
    end
    bus_rd(CLM0, 32'd0, "level_claim_again");
    bus_wr(CLM0, 32'd3);
    cycles(1);
    checks++;
    if (irq[0] !== 1'b1) begin
      errors++;
      $display("FAIL level_reassert: irq0 got %b expected 1", irq[0]);
    end
    bus_rd(CLM0, 32'd3, "level_reclaim");
  endtask

  task automatic test_edge;
    bus_wr(MODE, 32'h04);
    bus_wr(a_prio(2), 32'd4);
    bus_wr(EN0, 32'h0C);
    repeat (10) begin
      src[1] = 1'b1;
      cycles(1);
      src[1] = 1'b0;
      cycles(1);
    end
    cycles(1);
    checks++;
    if (irq[0] !== 1'b1) begin
      errors++;
      $display("FAIL edge_irq: irq0 got %b expected 1", irq[0]);
    end
    for (int k = 0; k < 8; k++) begin
      bus_rd(CLM0, 32'd2, "edge_claim");
      bus_wr(CLM0, 32'd2);
    end
    bus_rd(CLM0, 32'd0, "edge_claim_saturated_out");
    cycles(2);
    checks++;
    if (irq[0] !== 1'b0) begin
      errors++;
      $display("FAIL edge_irq_idle: irq0 got %b expected 0", irq[0]);
    end
  endtask

  task automatic test_tie;
    src[0] = 1'b1;
    src[3] = 1'b1;
    src[5] = 1'b1;
    bus_wr(a_prio(1), 32'd3);
    bus_wr(a_prio(4), 32'd3);
    bus_wr(a_prio(6), 32'd6);
    bus_wr(EN1, 32'h52);
    bus_wr(THR1, 32'd0);
    cycles(2);
    checks++;
    if (irq[1] !== 1'b1) begin
      errors++;
      $display("FAIL tie_irq: irq1 got %b expected 1", irq[1]);
    end
    bus_rd(CLM1, 32'd6, "tie_claim_prio6");
    bus_rd(CLM1, 32'd1, "tie_claim_id1");
    bus_rd(CLM1, 32'd4, "tie_claim_id4");
    cycles(2);
    checks++;
    if (irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL tie_all_in_service: irq1 got %b expected 0", irq[1]);
    end
    bus_wr(CLM1, 32'd6);
    bus_wr(CLM1, 32'd1);
    bus_wr(CLM1, 32'd4);
    cycles(2);
    checks++;
    if (irq[1] !== 1'b1) begin
      errors++;
      $display("FAIL tie_after_complete: irq1 got %b expected 1", irq[1]);
    end
    bus_wr(THR1, 32'd6);
    cycles(2);
    checks++;
    if (irq[1] !== 1'b0) begin
      errors++;
      $display("FAIL threshold_irq: irq1 got %b expected 0", irq[1]);
    end
    bus_rd(CLM1, 32'd0, "threshold_claim");
    bus_rd(THR1, 32'd6, "threshold_read");
  endtask

  task automatic test_complete_ignored;
    bus_rd(PEND, 32'h52, "ignored_pend_before");
    bus_wr(CLM0, 32'd5);
    bus_wr(CLM1, 32'd3);
    bus_rd(PEND, 32'h52, "ignored_pend_after");
    bus_wr(CLM0, 32'd3);
    bus_rd(PEND, 32'h5A, "valid_complete_pend");
  endtask

  task automatic test_edge_claim_collision;
    bus_wr(EN0, 32'h04);
    src[1] = 1'b1;
    cycles(1);
    src[1] = 1'b0;
    cycles(1);
    src[1] = 1'b1;
    bus_rd(CLM0, 32'd2, "collision_claim");
    bus_wr(CLM0, 32'd2);
    bus_rd(CLM0, 32'd2, "collision_count_kept");
    bus_wr(CLM0, 32'd2);
    bus_rd(CLM0, 32'd0, "collision_drained");
  endtask

  task automatic test_back_to_back;
    bus_rd(a_prio(3), 32'd5, "b2b_prio3");
    bus_rd(a_prio(6), 32'd6, "b2b_prio6");
    bus_rd(MODE, 32'h04, "b2b_mode");
    bus_wr(a_prio(7), 32'd2);
    bus_rd(a_prio(7), 32'd2, "b2b_prio7_after_write");
    bus_rd(EN1, 32'h52, "b2b_en1");
  endtask

  task automatic test_reset_mid;
    valid   = 1'b1;
    address = a_prio(3);
    wstrb   = 4'h0;
    rst     = 1'b0;
    @(posedge clk);
    #1;
    valid = 1'b0;
    cycles(1);
    rst = 1'b1;
    checks++;
    if (irq !== 2'b00) begin
      errors++;
      $display("FAIL midreset_irq: got %b expected 00", irq);
    end
    cycles(1);
    bus_rd(a_prio(3), 32'd0, "midreset_prio3");
    bus_rd(MODE, 32'h0, "midreset_mode");
    bus_rd(EN1, 32'h0, "midreset_en1");
    bus_rd(PEND, 32'h5E, "midreset_pend_level");
  endtask

  initial begin
    test_reset();
    test_level();
    test_edge();
    test_tie();
    test_complete_ignored();
    test_edge_claim_collision();
    test_back_to_back();
    test_reset_mid();
    cycles(2);
    checks++;
    if (sb_rd.size() != 0) begin
      errors++;
      $display("FAIL missing_ready: %0d requests unanswered expected 0", sb_rd.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
